// File: rtl/pat_stream.sv
// pat_stream: reads one pattern set from the pattern memory controller's
// output FIFO and streams it to the camera pattern interface.
// Each 64-bit FIFO word is unpacked into four 16-bit channel words, MSB first.
// The FIFO is non-FWFT, so each word costs a strobe cycle and a capture cycle.
// Optional feature: define PAT_LOOP_EN to re-request the pattern set after
// every frame and keep streaming until seq_stop.
module pat_stream #(
    parameter int WORDS_PER_PAT = 5632
) (
    input  logic        mem_clk,
    input  logic        fsm_rst,
    input  logic [31:0] num_pat,
    input  logic        write_done,
    input  logic        frame_start,
    input  logic        seq_stop,
    output logic        read_start,
    input  logic [63:0] outfifo_dout,
    input  logic        outfifo_empty,
    output logic        outfifo_rd_en,
    output logic [15:0] pat_data,
    output logic        pat_valid,
    input  logic        pat_ready,
    output logic        pat_last,
    output logic [15:0] pat_idx,
    output logic        frame_done,
    output logic        underrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;

    localparam logic [15:0] LAST_WORD = 16'(WORDS_PER_PAT - 1);

    logic [2:0]  state;
    logic [63:0] sreg;
    logic [1:0]  slot;
    logic [15:0] word_cnt;
    logic [31:0] pat_cnt;
    logic [31:0] num_pat_q;
    logic        pat_end;
    logic        frame_end;

    // All outputs are flops or decodes of flops; pat_ready only steers state.
    assign pat_data  = sreg[63:48];
    assign pat_idx   = pat_cnt[15:0];
    assign pat_end   = (word_cnt == LAST_WORD);
    assign pat_last  = pat_valid && pat_end;
    assign frame_end = pat_end && (pat_cnt == num_pat_q - 32'd1);

    // Main sequencer: request, fetch, capture and shift out the pattern set.
    always_ff @(posedge mem_clk or posedge fsm_rst) begin
        if (fsm_rst) begin
            state         <= S_IDLE;
            sreg          <= '0;
            slot          <= '0;
            word_cnt      <= '0;
            pat_cnt       <= '0;
            num_pat_q     <= '0;
            read_start    <= 1'b0;
            outfifo_rd_en <= 1'b0;
            pat_valid     <= 1'b0;
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (seq_stop) begin
                state         <= S_IDLE;
                read_start    <= 1'b0;
                outfifo_rd_en <= 1'b0;
                pat_valid     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_start && write_done && (num_pat != 32'd0)) begin
                            num_pat_q  <= num_pat;
                            word_cnt   <= '0;
                            pat_cnt    <= '0;
                            slot       <= '0;
                            underrun   <= 1'b0;
                            read_start <= 1'b1;
                            state      <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (!outfifo_empty) begin
                            read_start <= 1'b0;
                            state      <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (!outfifo_empty) begin
                            outfifo_rd_en <= 1'b1;
                            state         <= S_LOAD;
                        end else if (pat_ready) begin
                            underrun <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        // First LOAD cycle carries the strobe; the data arrives on the second.
                        if (outfifo_rd_en) begin
                            outfifo_rd_en <= 1'b0;
                        end else begin
                            sreg      <= outfifo_dout;
                            slot      <= '0;
                            pat_valid <= 1'b1;
                            state     <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (pat_ready) begin
                            sreg     <= {sreg[47:0], 16'h0000};
                            slot     <= slot + 2'd1;
                            word_cnt <= word_cnt + 16'd1;
                            if (pat_end) begin
                                word_cnt <= '0;
                                pat_cnt  <= pat_cnt + 32'd1;
                            end
                            if (frame_end) begin
                                frame_done <= 1'b1;
                                pat_valid  <= 1'b0;
`ifdef PAT_LOOP_EN
                                pat_cnt    <= '0;
                                read_start <= 1'b1;
                                state      <= S_REQ;
`else
                                state      <= S_IDLE;
`endif
                            end else if (slot == 2'd3) begin
                                pat_valid <= 1'b0;
                                state     <= S_FETCH;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pat_stream.sv
// tb_pat_stream: directed bench for pat_stream with a small non-FWFT FIFO
// model. Every FIFO word n carries channel words 4n+1..4n+4, so the expected
// stream for a frame is simply 1,2,3,... with pat_last every WPP words.
module tb_pat_stream;

    localparam int WPP = 8;

    logic        mem_clk = 1'b0;
    logic        fsm_rst;
    logic [31:0] num_pat;
    logic        write_done;
    logic        frame_start;
    logic        seq_stop;
    logic        read_start;
    logic [63:0] outfifo_dout = '0;
    logic        outfifo_empty;
    logic        outfifo_rd_en;
    logic [15:0] pat_data;
    logic        pat_valid;
    logic        pat_ready;
    logic        pat_last;
    logic [15:0] pat_idx;
    logic        frame_done;
    logic        underrun;

    logic [63:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_flush = 1'b0;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    logic [31:0] rdy_pat = 32'b1001_1010_0111_0001_1101_0010_1100_1011;
    logic        seen;

    pat_stream #(.WORDS_PER_PAT(WPP)) dut (
        .mem_clk       (mem_clk),
        .fsm_rst       (fsm_rst),
        .num_pat       (num_pat),
        .write_done    (write_done),
        .frame_start   (frame_start),
        .seq_stop      (seq_stop),
        .read_start    (read_start),
        .outfifo_dout  (outfifo_dout),
        .outfifo_empty (outfifo_empty),
        .outfifo_rd_en (outfifo_rd_en),
        .pat_data      (pat_data),
        .pat_valid     (pat_valid),
        .pat_ready     (pat_ready),
        .pat_last      (pat_last),
        .pat_idx       (pat_idx),
        .frame_done    (frame_done),
        .underrun      (underrun)
    );

    // Free-running clock.
    always #5 mem_clk = ~mem_clk;

    // Cycle counter for latency and throughput measurements.
    always @(posedge mem_clk) cyc <= cyc + 1;

    assign outfifo_empty = (rd_ptr >= wr_ptr);

    // Non-FWFT FIFO: data appears the cycle after the read strobe.
    always @(posedge mem_clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (outfifo_rd_en && (rd_ptr < wr_ptr)) begin
            outfifo_dout <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic pushWords(input int first_word, input int count);
        for (int k = 0; k < count; k++) begin
            int b;
            b = 4 * (first_word + k);
            fifo_mem[wr_ptr] = {16'(b + 1), 16'(b + 2), 16'(b + 3), 16'(b + 4)};
            wr_ptr++;
        end
    endtask

    task automatic applyStimulus();
        @(negedge mem_clk);
        frame_start = 1'b1;
        @(negedge mem_clk);
        frame_start = 1'b0;
    endtask

    task automatic stopSeq();
        @(negedge mem_clk);
        seq_stop   = 1'b1;
        fifo_flush = 1'b1;
        @(negedge mem_clk);
        seq_stop   = 1'b0;
        fifo_flush = 1'b0;
    endtask

    // Collect transfers from..to-1, checking data, last and index; with bp the
    // ready line follows rdy_pat and held words must not change.
    task automatic streamWords(input int from, input int to, input int frame_words, input bit bp);
        int          n = from;
        int          budget = 0;
        bit          hold = 1'b0;
        logic [15:0] hold_data = '0;
        while (n < to && budget < 400) begin
            @(negedge mem_clk);
            budget++;
            if (hold) begin
                checkOutput("hold_valid", 64'(pat_valid), 64'd1);
                checkOutput("hold_data", 64'(pat_data), 64'(hold_data));
            end
            pat_ready = bp ? rdy_pat[cyc % 32] : 1'b1;
            if (pat_valid && pat_ready) begin
                checkOutput("data", 64'(pat_data), 64'(n + 1));
                checkOutput("last", 64'(pat_last), 64'((n % WPP) == WPP - 1));
                checkOutput("idx", 64'(pat_idx), 64'(n / WPP));
                if (n == from) first_cyc = cyc;
                last_cyc = cyc;
                n++;
                hold = 1'b0;
            end else begin
                hold      = pat_valid;
                hold_data = pat_data;
            end
        end
        if (n < to) checkOutput("timeout", 64'(n), 64'(to));
        if (to == frame_words) begin
            @(negedge mem_clk);
            checkOutput("frame_done", 64'(frame_done), 64'd1);
            checkOutput("valid_after", 64'(pat_valid), 64'd0);
`ifdef PAT_LOOP_EN
            checkOutput("loop_req", 64'(read_start), 64'd1);
`else
            checkOutput("idle_req", 64'(read_start), 64'd0);
`endif
        end
    endtask

    // Directed test sequence.
    initial begin
        fsm_rst     = 1'b1;
        num_pat     = 32'd2;
        write_done  = 1'b0;
        frame_start = 1'b0;
        seq_stop    = 1'b0;
        pat_ready   = 1'b0;
        #12;
        checkOutput("reset_outs", {read_start, outfifo_rd_en, pat_valid, pat_last, frame_done, underrun, pat_data, pat_idx}, 64'd0);
        @(negedge mem_clk);
        fsm_rst = 1'b0;

        // Happy path with fixed latencies and 4 words per 7 cycles.
        pushWords(0, 4);
        write_done = 1'b1;
        applyStimulus();
        checkOutput("start_req", 64'(read_start), 64'd1);
        @(negedge mem_clk);
        checkOutput("req_drop", 64'({read_start, outfifo_rd_en}), 64'd0);
        @(negedge mem_clk);
        checkOutput("rd_strobe", 64'(outfifo_rd_en), 64'd1);
        @(negedge mem_clk);
        checkOutput("rd_single", 64'({outfifo_rd_en, pat_valid}), 64'd0);
        @(negedge mem_clk);
        checkOutput("first_valid", 64'({pat_valid, pat_data}), {47'd0, 1'b1, 16'd1});
        streamWords(0, 16, 16, 1'b0);
        checkOutput("throughput", 64'(last_cyc - first_cyc), 64'd24);
        @(negedge mem_clk);
        checkOutput("done_pulse", 64'(frame_done), 64'd0);
        checkOutput("no_underrun", 64'(underrun), 64'd0);
        stopSeq();

        // Back-pressure: same stream, held words stable.
        pushWords(0, 4);
        applyStimulus();
        streamWords(0, 16, 16, 1'b1);
        checkOutput("bp_underrun", 64'(underrun), 64'd0);
        stopSeq();

        // Gating: no write_done, then zero patterns.
        write_done = 1'b0;
        applyStimulus();
        seen = read_start;
        repeat (4) begin
            @(negedge mem_clk);
            seen = seen | read_start;
        end
        checkOutput("gate_wd", 64'({seen, pat_valid}), 64'd0);
        write_done = 1'b1;
        num_pat    = 32'd0;
        applyStimulus();
        seen = read_start;
        repeat (4) begin
            @(negedge mem_clk);
            seen = seen | read_start;
        end
        checkOutput("gate_np", 64'({seen, pat_valid}), 64'd0);
        num_pat = 32'd2;

        // Underrun: only one FIFO word available at first.
        pushWords(0, 1);
        applyStimulus();
        streamWords(0, 4, 16, 1'b0);
        repeat (3) @(negedge mem_clk);
        checkOutput("underrun_set", 64'({underrun, pat_valid}), 64'b10);
        pushWords(1, 3);
        streamWords(4, 16, 16, 1'b0);
        checkOutput("underrun_sticky", 64'(underrun), 64'd1);
        stopSeq();
        pushWords(0, 4);
        applyStimulus();
        checkOutput("underrun_clr", 64'(underrun), 64'd0);
        streamWords(0, 16, 16, 1'b0);
        stopSeq();

        // Abort mid-word, then confirm a fresh frame starts cleanly.
        pushWords(0, 4);
        applyStimulus();
        streamWords(0, 2, 16, 1'b0);
        @(negedge mem_clk);
        checkOutput("pre_stop_valid", 64'(pat_valid), 64'd1);
        pat_ready = 1'b0;
        seq_stop  = 1'b1;
        @(negedge mem_clk);
        seq_stop = 1'b0;
        checkOutput("stop_drop", 64'({pat_valid, read_start, outfifo_rd_en}), 64'd0);
        stopSeq();
        pushWords(0, 4);
        applyStimulus();
        checkOutput("restart_req", 64'(read_start), 64'd1);
        streamWords(0, 16, 16, 1'b0);
        stopSeq();

        // Asynchronous reset while shifting.
        pushWords(0, 4);
        applyStimulus();
        streamWords(0, 3, 16, 1'b0);
        @(negedge mem_clk);
        pat_ready = 1'b0;
        checkOutput("pre_rst_valid", 64'(pat_valid), 64'd1);
        #2 fsm_rst = 1'b1;
        #1;
        checkOutput("async_reset", {read_start, outfifo_rd_en, pat_valid, pat_last, frame_done, underrun, pat_data, pat_idx}, 64'd0);
        @(negedge mem_clk);
        fsm_rst = 1'b0;
        stopSeq();

`ifdef PAT_LOOP_EN
        // Looping: two passes of a one-pattern frame, then stop.
        num_pat = 32'd1;
        pushWords(0, 2);
        pushWords(0, 2);
        applyStimulus();
        streamWords(0, 8, 8, 1'b0);
        streamWords(0, 8, 8, 1'b0);
        stopSeq();
        checkOutput("loop_stop", 64'({read_start, pat_valid}), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net in case a wait is ever left unbounded.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
